dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the dCPU bus: serves the CPU's active-low R/W strobes, 8-bit address, and write data from a 256x8 internal RAM.
- Memory-mapped output port at address 0xFF.
- Configurable wait states plus a ready pulse, so a later stalling CPU revision can use it unchanged.
- Backdoor load port lets the bench or a boot loader preload programs.

Parameters:
- WAIT_STATES, 0, extra cycles inserted before a transfer completes (0..15).
- OUT_ADDR, 8'hFF, address decoded to the output port register instead of RAM.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- addr  input  8  bus address from CPU.
- R  input  1  read strobe, active low.
- W  input  1  write strobe, active low.
- data_in  input  8  write data from CPU (CPU data_out).
- mem_out  output  8  read data to CPU (CPU mem_in).
- ready  output  1  one-cycle pulse: transfer complete.
- err  output  1  sticky: R and W were both low at request sample.
- out_port  output  8  memory-mapped output register.
- load_en  input  1  backdoor RAM write enable.
- load_addr  input  8  backdoor address.
- load_data  input  8  backdoor data.

Behaviour:
- Reset (sync, rst high at posedge):
  - Values: state=IDLE, wait counter=0, rdata=0, ready=0, err=0, out_port=0.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts it: no RAM/out_port write, no ready pulse.
- FSM has 2 states: IDLE, BUSY.
- IDLE:
  - At posedge with R==0 or W==0: latch addr, data_in, and op (RD / WR / BOTH).
  - Load counter with WAIT_STATES, go to BUSY.
  - Strobes high: stay IDLE.
- BUSY:
  - Counter != 0: decrement; bus inputs are ignored (latched copies are used).
  - Counter == 0: perform access, assert ready for exactly that cycle's registered output, return to IDLE.
- Latency: ready is high in the cycle after the (WAIT_STATES+2)th posedge counted from the request posedge. With WAIT_STATES=0, ready rises 2 posedges after the request is sampled.
- Access:
  - RD: rdata <= RAM[a], or out_port if a==OUT_ADDR.
  - WR: RAM[a] <= d, or out_port <= d if a==OUT_ADDR. A write to OUT_ADDR does not touch RAM.
  - BOTH: no read or write; err <= 1 (sticky until rst); ready still pulses; rdata unchanged.
- mem_out: combinational; equals rdata while R==0, else 8'h00. rdata holds its last read value until the next completed read.
- Back-to-back: if a strobe is still low in the IDLE cycle after completion, a new transfer starts. A held strobe therefore repeats the access every WAIT_STATES+2 cycles (idempotent for reads).
- Backdoor load:
  - load_en writes RAM[load_addr] at posedge in any state, including during a transfer.
  - If a bus WR to the same RAM address completes in the same cycle, load wins.
  - load_addr==OUT_ADDR writes RAM, not out_port.
- Address arithmetic is 8-bit, with no wrap logic needed. The counter is 4-bit; WAIT_STATES>15 is illegal (elaboration error).

Test Plan:
- Preload via load port RAM[0x10]=0x5A; WAIT_STATES=0; R low with addr=0x10 -> ready pulses 2 posedges after sample, mem_out=0x5A while R low, 0x00 once R high.
- WAIT_STATES=3; W low, addr=0x20, data_in=0x77 for one cycle, then change data_in to 0x11 -> ready after 5 posedges, then read 0x20 returns 0x77 (latched data, not 0x11).
- Write 0xC3 to addr 0xFF -> out_port=0xC3, RAM[0xFF] unchanged (preloaded 0x00 reads back via load then bus read of 0xFF returns 0xC3 from out_port).
- R and W both low at addr 0x30 -> ready pulses, err=1 and stays 1 through later valid transfers, RAM[0x30] unchanged; rst -> err=0.
- WAIT_STATES=4, start write to 0x40=0x99, assert rst on 2nd BUSY cycle -> no ready pulse, RAM[0x40] keeps prior value, state IDLE, out_port=0.
- Same-cycle completion of bus WR to 0x50=0x01 and load_en to 0x50=0x02 -> RAM[0x50]=0x02; run dCPU program LOADA 0 / ADD 16 / JMPZ 8 / JMP 2 against block with WAIT_STATES=0 -> acc sequence matches direct-memory model.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: dCPU bus memory responder with wait states, ready pulse, mapped output port and backdoor load.
module dmem_responder #(
  parameter int WAIT_STATES = 0,
  parameter logic [7:0] OUT_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       R,
  input  logic       W,
  input  logic [7:0] data_in,
  output logic [7:0] mem_out,
  output logic       ready,
  output logic       err,
  output logic [7:0] out_port,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data
);
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be in 0..15");
  end
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BOTH} op_t;
  state_t     state;
  op_t        op;
  logic [3:0] cnt;
  logic [7:0] a, d, rdata;
  logic [7:0] ram [256];
  logic       done, do_wr;
  assign done    = state == BUSY && cnt == 4'd0;
  assign do_wr   = !rst && done && op == OP_WR && a != OUT_ADDR;
  assign mem_out = !R ? rdata : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rdata    <= 8'h00;
      ready    <= 1'b0;
      err      <= 1'b0;
      out_port <= 8'h00;
    end else begin
      ready <= 1'b0;
      if (state == IDLE) begin
        if (!R || !W) begin
          a     <= addr;
          d     <= data_in;
          op    <= (!R && !W) ? OP_BOTH : !R ? OP_RD : OP_WR;
          cnt   <= WS;
          state <= BUSY;
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        ready <= 1'b1;
        state <= IDLE;
        if (op == OP_RD) rdata <= a == OUT_ADDR ? out_port : ram[a];
        if (op == OP_WR && a == OUT_ADDR) out_port <= d;
        if (op == OP_BOTH) err <= 1'b1;
      end
    end
  end
  // Backdoor load comes last so it overrides a same-cycle bus write.
  always_ff @(posedge clk) begin
    if (do_wr) ram[a] <= d;
    if (load_en) ram[load_addr] <= load_data;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responder instances (0, 3 and 4 wait states) sharing one bus.
module tb_dmem_responder;
  logic       clk = 0, rst = 1, R = 1, W = 1, load_en = 0;
  logic [7:0] addr = 0, data_in = 0, load_addr = 0, load_data = 0;
  logic [7:0] mem_out [3];
  logic [7:0] out_port [3];
  logic [2:0] ready, err;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mdl [256];
  logic [7:0] acc_q [$];

  dmem_responder #(.WAIT_STATES(0)) d0 (.clk(clk), .rst(rst), .addr(addr), .R(R), .W(W), .data_in(data_in),
    .mem_out(mem_out[0]), .ready(ready[0]), .err(err[0]), .out_port(out_port[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  dmem_responder #(.WAIT_STATES(3)) d3 (.clk(clk), .rst(rst), .addr(addr), .R(R), .W(W), .data_in(data_in),
    .mem_out(mem_out[1]), .ready(ready[1]), .err(err[1]), .out_port(out_port[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  dmem_responder #(.WAIT_STATES(4)) d4 (.clk(clk), .rst(rst), .addr(addr), .R(R), .W(W), .data_in(data_in),
    .mem_out(mem_out[2]), .ready(ready[2]), .err(err[2]), .out_port(out_port[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    R = 1;
    W = 1;
    repeat (12) tick;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1;
    load_addr = a;
    load_data = d;
    tick;
    load_en = 0;
  endtask

  // Drive a request, then scramble bus inputs so only latched copies can be used.
  task automatic xfer(input int s, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp, output logic [7:0] q, output int n);
    logic rd;
    rd = !r && w;
    R = r;
    W = w;
    addr = a;
    data_in = d;
    if (rd) exp_q.push_back(exp);
    tick;
    addr = ~a;
    data_in = d ^ 8'h66;
    n = 1;
    do begin
      tick;
      n++;
    end while (!ready[s] && n < 40);
    chk("ready_seen", ready[s], 1'b1);
    q = mem_out[s];
    if (rd) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("rdata", q, exp_q.pop_front());
    end
    R = 1;
    W = 1;
    #1;
    chk("mem_out_released", mem_out[s], 8'h00);
    tick;
    chk("ready_one_cycle", ready[s], 1'b0);
    drain;
  endtask

  task automatic fetch(input bit bus, input logic [7:0] a, output logic [7:0] v);
    int n;
    if (bus) xfer(0, 0, 1, a, 8'h00, mdl[a], v, n);
    else v = mdl[a];
  endtask

  // Tiny accumulator CPU: 1=LOADA imm, 2=ADD mem, 3=JMPZ, 4=JMP, 0=halt.
  task automatic run(input bit bus);
    logic [7:0] pc, op, arg, m, acc;
    bit halted;
    pc = 0;
    acc = 0;
    halted = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      fetch(bus, pc, op);
      fetch(bus, pc + 8'd1, arg);
      pc = pc + 8'd2;
      case (op)
        8'd0: halted = 1;
        8'd3: if (acc == 0) pc = arg;
        8'd4: pc = arg;
        default: begin
          if (op == 8'd2) begin
            fetch(bus, arg, m);
            acc = acc + m;
          end else acc = arg;
          if (!bus) acc_q.push_back(acc);
          else if (acc_q.size() == 0) chk("cpu_acc_extra", 1, 0);
          else chk("cpu_acc", acc, acc_q.pop_front());
        end
      endcase
    end
    if (bus) begin
      chk("cpu_halted", halted, 1'b1);
      chk("cpu_acc_all_seen", acc_q.size(), 0);
    end
  endtask

  initial begin
    logic [7:0] q;
    int n;
    bit seen;
    repeat (3) tick;
    rst = 0;
    chk("rst_ready", ready, 3'b000);
    chk("rst_err", err, 3'b000);
    chk("rst_out_port", out_port[0], 8'h00);
    chk("rst_mem_out_idle", mem_out[0], 8'h00);
    R = 0;
    #1;
    chk("rst_rdata", mem_out[0], 8'h00);
    R = 1;
    tick;

    load(8'h10, 8'h5A);
    xfer(0, 0, 1, 8'h10, 8'h00, 8'h5A, q, n);
    chk("ws0_latency", n, 2);

    xfer(1, 1, 0, 8'h20, 8'h77, 8'h00, q, n);
    chk("ws3_wr_latency", n, 5);
    xfer(1, 0, 1, 8'h20, 8'h00, 8'h77, q, n);
    chk("ws3_rd_latency", n, 5);

    load(8'hFF, 8'h00);
    xfer(0, 1, 0, 8'hFF, 8'hC3, 8'h00, q, n);
    chk("out_port_write", out_port[0], 8'hC3);
    chk("out_addr_ram_untouched", d0.ram[8'hFF], 8'h00);
    xfer(0, 0, 1, 8'hFF, 8'h00, 8'hC3, q, n);

    load(8'h30, 8'h33);
    xfer(0, 0, 0, 8'h30, 8'hEE, 8'h00, q, n);
    chk("both_latency", n, 2);
    chk("both_err", err[0], 1'b1);
    xfer(0, 0, 1, 8'h30, 8'h00, 8'h33, q, n);
    chk("err_sticky", err[0], 1'b1);
    rst = 1;
    tick;
    rst = 0;
    chk("err_cleared", err[0], 1'b0);

    xfer(2, 1, 0, 8'hFF, 8'h5C, 8'h00, q, n);
    chk("ws4_out_port", out_port[2], 8'h5C);
    load(8'h40, 8'h44);
    W = 0;
    addr = 8'h40;
    data_in = 8'h99;
    seen = 0;
    tick;
    seen |= ready[2];
    tick;
    seen |= ready[2];
    rst = 1;
    tick;
    rst = 0;
    W = 1;
    for (int i = 0; i < 10; i++) begin
      seen |= ready[2];
      tick;
    end
    chk("abort_no_ready", seen, 1'b0);
    chk("abort_out_port", out_port[2], 8'h00);
    xfer(2, 0, 1, 8'h40, 8'h00, 8'h44, q, n);
    chk("abort_idle_latency", n, 6);

    W = 0;
    addr = 8'h50;
    data_in = 8'h01;
    tick;
    addr = 8'h00;
    data_in = 8'h00;
    load_en = 1;
    load_addr = 8'h50;
    load_data = 8'h02;
    tick;
    load_en = 0;
    chk("collide_ready", ready[0], 1'b1);
    drain;
    xfer(0, 0, 1, 8'h50, 8'h00, 8'h02, q, n);

    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl[0] = 8'h01; mdl[1] = 8'h00; mdl[2] = 8'h02; mdl[3] = 8'h10;
    mdl[4] = 8'h03; mdl[5] = 8'h08; mdl[6] = 8'h04; mdl[7] = 8'h02;
    mdl[16] = 8'h40;
    for (int i = 0; i < 10; i++) load(8'(i), mdl[i]);
    load(8'h10, mdl[16]);
    run(0);
    chk("cpu_model_len", acc_q.size(), 5);
    run(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
